ps2_cmd_sender: RTL and testbench
=================================

PS2_CMD_SENDER -- requirements
Module: ps2_cmd_sender

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 6000: CLOCK_50 cycles PS2_CLK is held low before a request (120 us).
REQ-002 Parameter START_TIMEOUT, default 750000: maximum cycles from clock release to the first device falling edge (15 ms).
REQ-003 Parameter XFER_TIMEOUT, default 100000: maximum cycles from the first falling edge to transfer end (2 ms).
REQ-004 CLOCK_50  input  1  system clock, 50 MHz; all logic is on its rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 cmd_data  input  8  command byte to send to the keyboard (e.g. 8'hED LED set).
REQ-007 cmd_valid  input  1  request; the byte is accepted in the cycle cmd_valid=1 and cmd_ready=1.
REQ-008 cmd_ready  output  1  high only in IDLE.
REQ-009 PS2_CLK  inout  1  open-drain; the block drives 0 or releases (high-Z).
REQ-010 PS2_DAT  inout  1  open-drain; the block drives 0 or releases (high-Z).
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 cmd_sent  output  1  one-cycle pulse when the device ACK is received.
REQ-013 cmd_error  output  1  one-cycle pulse on timeout or missing ACK.

Function
REQ-014 The block SHALL synchronise PS2_CLK and PS2_DAT with 2 flops each and SHALL detect a falling edge as prev=1, curr=0 on the synchronised clock.
REQ-015 On acceptance the block SHALL latch cmd_data and compute odd parity = ~^cmd_data.
REQ-016 IDLE: both lines released; the FSM moves to INHIBIT on acceptance.
REQ-017 INHIBIT: drive PS2_CLK low for exactly INHIBIT_CYCLES cycles, then enter REQ.
REQ-018 REQ: drive PS2_DAT low (start bit) for 1 cycle with PS2_CLK still low, then release PS2_CLK and enter WAIT1 with the timeout counter cleared.
REQ-019 WAIT1: keep PS2_DAT low; on falling edge 1 enter DATA and present d0; if START_TIMEOUT cycles elapse with no edge, enter ERR.
REQ-020 DATA: on falling edges 2..8 present d1..d7 (LSB first), using a 3-bit bit counter; after d7 is presented, the next falling edge presents parity and the FSM enters PARITY.
REQ-021 PARITY: on the next falling edge (edge 10) release PS2_DAT (stop bit = 1) and enter ACK.
REQ-022 ACK: on falling edge 11 sample synchronised PS2_DAT; 0 -> WAITHI, 1 -> ERR.
REQ-023 WAITHI: wait until both synchronised lines read 1, then pulse cmd_sent and return to IDLE.
REQ-024 Driving 0 means output-enable asserted; driving 1 means release. The block SHALL never actively drive a high level.
REQ-025 From edge 1 to the end of WAITHI, a single counter SHALL enforce XFER_TIMEOUT; expiry -> ERR.
REQ-026 ERR: release both lines, pulse cmd_error for 1 cycle, return to IDLE the next cycle.
REQ-027 cmd_valid while busy=1 SHALL be ignored, with no queuing.
REQ-028 Timeout counters SHALL be 20 bits wide and SHALL saturate, never wrap.
REQ-029 cmd_sent and cmd_error SHALL never be asserted in the same cycle.

Reset
REQ-030 While resetn=0, asynchronously: state=IDLE; both lines released; cmd_ready=0; busy=0; cmd_sent=0; cmd_error=0; counters and the data latch cleared.
REQ-031 cmd_ready SHALL rise the first cycle after resetn deasserts.
REQ-032 Reset asserted mid-transfer SHALL release both lines immediately, with no pulse on cmd_sent or cmd_error.

Verification
REQ-033 Send 8'hED to a device model clocking at 12.5 kHz, ACK low -> PS2_CLK low for 6000 cycles; bits 1,0,1,1,0,1,1,1 then parity 1; cmd_sent pulses once; busy falls.
REQ-034 Send 8'h00 and then 8'h01 -> parity bits 1 and 0 respectively; both transfers complete with cmd_sent.
REQ-035 Device leaves DAT high on edge 11 -> cmd_error pulse; no cmd_sent; lines released.
REQ-036 Device never clocks after release -> cmd_error exactly 750000 cycles after PS2_CLK release.
REQ-037 Device stops after 5 edges -> cmd_error 100000 cycles after edge 1; a following 8'hF4 request then completes normally.
REQ-038 Pulse resetn low at edge 4; also pulse cmd_valid during DATA -> lines released at once, no pulses; the second request is ignored.

Source files
------------

// File: rtl/ps2_cmd_sender.sv
// rtl/ps2_cmd_sender.sv - PS/2 host-to-device command sender with open-drain line control
module ps2_cmd_sender #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int START_TIMEOUT  = 750000,
    parameter int XFER_TIMEOUT   = 100000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT,
    output logic       busy,
    output logic       cmd_sent,
    output logic       cmd_error
);

    localparam logic [19:0] INHIBIT_LAST = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] START_LAST   = 20'(START_TIMEOUT - 1);
    localparam logic [19:0] XFER_LAST    = 20'(XFER_TIMEOUT - 1);
    localparam logic [19:0] CNT_MAX      = 20'hFFFFF;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_WAIT1,
        S_DATA,
        S_PARITY,
        S_ACK,
        S_WAITHI,
        S_ERR
    } state_t;

    state_t      state;
    logic [1:0]  clk_sync;
    logic [1:0]  dat_sync;
    logic        clk_prev;
    logic        clk_fall;
    logic        clk_oe;
    logic        dat_oe;
    logic [7:0]  data_q;
    logic        parity_q;
    logic [2:0]  bit_cnt;
    logic [19:0] tcnt;
    logic [19:0] tcnt_inc;

    // Open-drain: an asserted enable pulls the line low, otherwise it floats to the pull-up.
    assign PS2_CLK = clk_oe ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_oe ? 1'b0 : 1'bz;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], PS2_CLK};
            dat_sync <= {dat_sync[0], PS2_DAT};
            clk_prev <= clk_sync[1];
        end
    end

    assign clk_fall = clk_prev & ~clk_sync[1];
    assign tcnt_inc = (tcnt == CNT_MAX) ? tcnt : tcnt + 20'd1;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            clk_oe    <= 1'b0;
            dat_oe    <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            cmd_sent  <= 1'b0;
            cmd_error <= 1'b0;
            data_q    <= 8'd0;
            parity_q  <= 1'b0;
            bit_cnt   <= 3'd0;
            tcnt      <= 20'd0;
        end else begin
            cmd_sent  <= 1'b0;
            cmd_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    clk_oe    <= 1'b0;
                    dat_oe    <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        data_q    <= cmd_data;
                        parity_q  <= ~^cmd_data;
                        clk_oe    <= 1'b1;
                        tcnt      <= 20'd0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_INHIBIT;
                    end
                end

                S_INHIBIT: begin
                    if (tcnt >= INHIBIT_LAST) begin
                        dat_oe <= 1'b1;
                        state  <= S_REQ;
                    end else begin
                        tcnt <= tcnt_inc;
                    end
                end

                S_REQ: begin
                    clk_oe <= 1'b0;
                    tcnt   <= 20'd0;
                    state  <= S_WAIT1;
                end

                S_WAIT1: begin
                    if (clk_fall) begin
                        dat_oe  <= ~data_q[0];
                        bit_cnt <= 3'd1;
                        tcnt    <= 20'd0;
                        state   <= S_DATA;
                    end else if (tcnt >= START_LAST) begin
                        clk_oe    <= 1'b0;
                        dat_oe    <= 1'b0;
                        cmd_error <= 1'b1;
                        state     <= S_ERR;
                    end else begin
                        tcnt <= tcnt_inc;
                    end
                end

                // One transfer-wide timer runs from the first device edge until the lines go idle.
                S_DATA, S_PARITY, S_ACK, S_WAITHI: begin
                    if (tcnt >= XFER_LAST) begin
                        clk_oe    <= 1'b0;
                        dat_oe    <= 1'b0;
                        cmd_error <= 1'b1;
                        state     <= S_ERR;
                    end else begin
                        tcnt <= tcnt_inc;
                        case (state)
                            S_DATA: begin
                                if (clk_fall) begin
                                    if (bit_cnt == 3'd0) begin
                                        dat_oe <= ~parity_q;
                                        state  <= S_PARITY;
                                    end else begin
                                        dat_oe  <= ~data_q[bit_cnt];
                                        bit_cnt <= bit_cnt + 3'd1;
                                    end
                                end
                            end
                            S_PARITY: begin
                                if (clk_fall) begin
                                    dat_oe <= 1'b0;
                                    state  <= S_ACK;
                                end
                            end
                            S_ACK: begin
                                if (clk_fall) begin
                                    if (!dat_sync[1]) begin
                                        state <= S_WAITHI;
                                    end else begin
                                        cmd_error <= 1'b1;
                                        state     <= S_ERR;
                                    end
                                end
                            end
                            S_WAITHI: begin
                                if (clk_sync[1] && dat_sync[1]) begin
                                    cmd_sent  <= 1'b1;
                                    cmd_ready <= 1'b1;
                                    busy      <= 1'b0;
                                    state     <= S_IDLE;
                                end
                            end
                            default: begin
                                state <= S_ERR;
                            end
                        endcase
                    end
                end

                S_ERR: begin
                    clk_oe    <= 1'b0;
                    dat_oe    <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end

                default: begin
                    clk_oe <= 1'b0;
                    dat_oe <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_cmd_sender.sv
// tb/tb_ps2_cmd_sender.sv - bench for ps2_cmd_sender with a clocking PS/2 device model
module tb_ps2_cmd_sender;

    localparam int INH      = 60;
    localparam int ST       = 3000;
    localparam int XT       = 1500;
    localparam int HALF     = 20;
    localparam int SYNC_LAT = 3;
    localparam int LIMIT    = ST + XT + 500;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] cmd_data = 8'd0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       busy;
    logic       cmd_sent;
    logic       cmd_error;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    wire        ps2_clk;
    wire        ps2_dat;

    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;
    pullup pu_clk (ps2_clk);
    pullup pu_dat (ps2_dat);

    always #10 clk = ~clk;

    ps2_cmd_sender #(
        .INHIBIT_CYCLES(INH),
        .START_TIMEOUT (ST),
        .XFER_TIMEOUT  (XT)
    ) dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .cmd_data (cmd_data),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .PS2_CLK  (ps2_clk),
        .PS2_DAT  (ps2_dat),
        .busy     (busy),
        .cmd_sent (cmd_sent),
        .cmd_error(cmd_error)
    );

    typedef struct {
        logic [7:0] data;
        logic       ack_low;
        int         edges;
        logic       par;
        logic       sent;
        logic       err;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       sent;
        logic       err;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int n_sent = 0;
    int n_err  = 0;
    int n_both = 0;
    int t_err  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (cmd_sent) n_sent++;
        if (cmd_error) begin
            n_err++;
            t_err = cyc;
        end
        if (cmd_sent && cmd_error) n_both++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 100; k++) begin
            if (cmd_ready === 1'b1) break;
            @(negedge clk);
        end
        check("ready_before_request", cmd_ready, 1'b1);
    endtask

    task automatic run_vec(input vec_t v);
        int         s0, e0, inh, t_rel, t_e1;
        logic       rts, got_out;
        logic [9:0] got;
        exp_t       ex;
        got = '0;
        t_rel = 0;
        t_e1 = 0;
        wait_ready();
        s0 = n_sent;
        e0 = n_err;
        @(negedge clk);
        cmd_data  = v.data;
        cmd_valid = 1'b1;
        sb.push_back('{data: v.data, par: v.par, sent: v.sent, err: v.err});
        @(negedge clk);
        cmd_valid = 1'b0;
        check("busy_after_accept", busy, 1'b1);
        inh = 0;
        rts = 1'b0;
        for (int k = 0; k < INH + 50; k++) begin
            if (ps2_clk === 1'b0 && ps2_dat === 1'b1) inh++;
            else if (ps2_clk === 1'b1 && ps2_dat === 1'b0) begin
                rts = 1'b1;
                t_rel = cyc;
                break;
            end
            @(negedge clk);
        end
        check("request_to_send_seen", rts, 1'b1);
        check("inhibit_len", inh, INH);
        if (v.edges > 0) repeat (HALF) @(negedge clk);
        for (int e = 1; e <= v.edges; e++) begin
            if (e == 1) t_e1 = cyc;
            if (e == 11 && v.ack_low) dev_dat_low = 1'b1;
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            if (e <= 10) got[e-1] = ps2_dat;
            dev_clk_low = 1'b0;
            if (e == 11) dev_dat_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        got_out = 1'b0;
        for (int k = 0; k < LIMIT; k++) begin
            if (n_sent != s0 || n_err != e0) begin
                got_out = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (30) @(negedge clk);
        check("outcome_seen", got_out, 1'b1);
        ex = sb.pop_front();
        check("sent_pulses", n_sent - s0, {31'd0, ex.sent});
        check("error_pulses", n_err - e0, {31'd0, ex.err});
        if (v.edges >= 10) begin
            check("frame_data", got[7:0], ex.data);
            check("frame_parity", got[8], ex.par);
            check("frame_stop", got[9], 1'b1);
        end
        if (v.edges == 0) check("start_timeout_cycles", t_err - t_rel, ST);
        if (v.edges > 0 && v.edges < 10) check("xfer_timeout_cycles", t_err - t_e1, XT + SYNC_LAT);
        check("idle_busy", busy, 1'b0);
        check("idle_ready", cmd_ready, 1'b1);
        check("idle_clk_released", ps2_clk, 1'b1);
        check("idle_dat_released", ps2_dat, 1'b1);
    endtask

    task automatic reset_mid_transfer();
        int s0, e0;
        wait_ready();
        @(negedge clk);
        cmd_data  = 8'h00;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 0; k < INH + 50; k++) begin
            if (ps2_clk === 1'b1 && ps2_dat === 1'b0) break;
            @(negedge clk);
        end
        repeat (HALF) @(negedge clk);
        for (int e = 1; e <= 4; e++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            if (e == 2) begin
                cmd_data  = 8'hAA;
                cmd_valid = 1'b1;
                @(negedge clk);
                cmd_valid = 1'b0;
                check("ignored_req_busy", busy, 1'b1);
                check("ignored_req_ready", cmd_ready, 1'b0);
            end
            if (e == 4) begin
                check("pre_reset_dat_driven", ps2_dat, 1'b0);
                s0 = n_sent;
                e0 = n_err;
                resetn = 1'b0;
                #1;
                check("reset_dat_released", ps2_dat, 1'b0 ^ 1'b1);
                check("reset_busy", busy, 1'b0);
                check("reset_ready", cmd_ready, 1'b0);
                check("reset_sent", cmd_sent, 1'b0);
                check("reset_error", cmd_error, 1'b0);
            end else begin
                dev_clk_low = 1'b0;
                repeat (HALF) @(negedge clk);
            end
        end
        @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (100) @(negedge clk);
        check("post_reset_no_sent", n_sent - s0, 0);
        check("post_reset_no_error", n_err - e0, 0);
        check("post_reset_idle", busy, 1'b0);
        check("post_reset_ready", cmd_ready, 1'b1);
        check("post_reset_clk_released", ps2_clk, 1'b1);
    endtask

    initial begin
        vecs[0] = '{data: 8'hED, ack_low: 1'b1, edges: 11, par: 1'b1, sent: 1'b1, err: 1'b0};
        vecs[1] = '{data: 8'h00, ack_low: 1'b1, edges: 11, par: 1'b1, sent: 1'b1, err: 1'b0};
        vecs[2] = '{data: 8'h01, ack_low: 1'b1, edges: 11, par: 1'b0, sent: 1'b1, err: 1'b0};
        vecs[3] = '{data: 8'hED, ack_low: 1'b0, edges: 11, par: 1'b1, sent: 1'b0, err: 1'b1};
        vecs[4] = '{data: 8'h3C, ack_low: 1'b1, edges: 0,  par: 1'b1, sent: 1'b0, err: 1'b1};
        vecs[5] = '{data: 8'h55, ack_low: 1'b1, edges: 5,  par: 1'b1, sent: 1'b0, err: 1'b1};
        vecs[6] = '{data: 8'hF4, ack_low: 1'b1, edges: 11, par: 1'b0, sent: 1'b1, err: 1'b0};

        repeat (3) @(negedge clk);
        check("rst_ready", cmd_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sent", cmd_sent, 1'b0);
        check("rst_error", cmd_error, 1'b0);
        check("rst_clk_released", ps2_clk, 1'b1);
        check("rst_dat_released", ps2_dat, 1'b1);
        resetn = 1'b1;
        @(negedge clk);
        check("ready_first_cycle", cmd_ready, 1'b1);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);
        reset_mid_transfer();
        run_vec(vecs[0]);

        check("no_simultaneous_pulse", n_both, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
